// File: rtl/seq_mult_param.sv
// seq_mult_param: sequential shift-and-add multiplier.
// It multiplies two WIDTH-bit operands, either unsigned or two's complement.
// Latency is fixed at WIDTH+1 cycles from the accepting edge to the done pulse.
// Signed operands are reduced to unsigned magnitudes plus a sign bit.
// The unsigned product is negated in the FINISH state when the result is negative.
// WIDTH is intended to lie in the range 2..32.
module seq_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 signed_mode,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // The counter must be able to hold the value WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   P_ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] P_ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      P_CNT_W  = CW'(WIDTH);
  localparam logic [CW-1:0]      P_CNT_1  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_done;

  state_t               w_state_next;
  logic [CW-1:0]        w_count_next;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]     w_mcand_next;
  logic [WIDTH-1:0]     w_mplier_next;
  logic                 w_neg_next;
  logic [2*WIDTH-1:0]   w_product_next;
  logic                 w_done_next;

  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_any_zero;
  logic                 w_res_neg;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_step_acc;

  // Operand magnitudes and result sign, taken from the live inputs at the accepting edge.
  // The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1).
  // That value still fits in WIDTH unsigned bits, so no extra width is needed.
  always_comb begin
    w_a_neg    = signed_mode & multiplicand[WIDTH-1];
    w_b_neg    = signed_mode & multiplier[WIDTH-1];
    w_a_mag    = w_a_neg ? (~multiplicand + P_ONE_W) : multiplicand;
    w_b_mag    = w_b_neg ? (~multiplier + P_ONE_W) : multiplier;
    w_any_zero = (multiplicand == '0) || (multiplier == '0);
    w_res_neg  = (w_a_neg ^ w_b_neg) & ~w_any_zero;
  end

  // One shift-and-add step.
  // The sum is added into the upper half and carries one extra bit.
  // Shifting {carry, acc} right by one keeps the full product exact after WIDTH steps.
  always_comb begin
    w_addend   = r_mplier[0] ? r_mcand : '0;
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    w_step_acc = {w_sum, r_acc[WIDTH-1:1]};
  end

  // Next-state and datapath logic; every register holds its value unless the current state updates it.
  always_comb begin
    w_state_next   = r_state;
    w_count_next   = r_count;
    w_acc_next     = r_acc;
    w_mcand_next   = r_mcand;
    w_mplier_next  = r_mplier;
    w_neg_next     = r_neg;
    w_product_next = r_product;
    w_done_next    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_mcand_next  = w_a_mag;
          w_mplier_next = w_b_mag;
          w_neg_next    = w_res_neg;
          w_count_next  = P_CNT_W;
          w_acc_next    = '0;
          w_state_next  = S_CALC;
        end
      end
      S_CALC: begin
        w_acc_next    = w_step_acc;
        w_mplier_next = {1'b0, r_mplier[WIDTH-1:1]};
        w_count_next  = r_count - P_CNT_1;
        if (r_count == P_CNT_1) begin
          w_state_next = S_FINISH;
        end
      end
      S_FINISH: begin
        w_product_next = r_neg ? (~r_acc + P_ONE_2W) : r_acc;
        w_done_next    = 1'b1;
        w_state_next   = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  // An asynchronous reset aborts any operation in flight without producing a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_count   <= w_count_next;
      r_acc     <= w_acc_next;
      r_mcand   <= w_mcand_next;
      r_mplier  <= w_mplier_next;
      r_neg     <= w_neg_next;
      r_product <= w_product_next;
      r_done    <= w_done_next;
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed and randomised checks of seq_mult_param at WIDTH = 3, 8 and 16.
module tb_seq_mult_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sm;
  logic        start3, start8, start16;
  logic        busy3, busy8, busy16;
  logic        done3, done8, done16;
  logic [5:0]  prod3;
  logic [15:0] prod8;
  logic [31:0] prod16;

  int n_checks = 0;
  int n_errors = 0;
  int n_done3 = 0, n_done8 = 0, n_done16 = 0;
  int n_exp3 = 0, n_exp8 = 0, n_exp16 = 0;

  always #5 clk = ~clk;

  seq_mult_param #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .multiplicand(op_a[2:0]), .multiplier(op_b[2:0]),
    .signed_mode(op_sm), .start(start3), .busy(busy3), .done(done3), .product(prod3));

  seq_mult_param #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .multiplicand(op_a[7:0]), .multiplier(op_b[7:0]),
    .signed_mode(op_sm), .start(start8), .busy(busy8), .done(done8), .product(prod8));

  seq_mult_param #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .multiplicand(op_a[15:0]), .multiplier(op_b[15:0]),
    .signed_mode(op_sm), .start(start16), .busy(busy16), .done(done16), .product(prod16));

  // Count the done pulses seen on each instance.
  always @(posedge clk) begin
    if (done3)  n_done3  <= n_done3 + 1;
    if (done8)  n_done8  <= n_done8 + 1;
    if (done16) n_done16 <= n_done16 + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_busy(input int w);
    case (w)
      3:       return busy3;
      8:       return busy8;
      default: return busy16;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      3:       return done3;
      8:       return done8;
      default: return done16;
    endcase
  endfunction

  function automatic logic [63:0] get_prod(input int w);
    case (w)
      3:       return {58'd0, prod3};
      8:       return {48'd0, prod8};
      default: return {32'd0, prod16};
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      3:       start3  = v;
      8:       start8  = v;
      default: start16 = v;
    endcase
  endtask

  task automatic bump_exp(input int w);
    case (w)
      3:       n_exp3++;
      8:       n_exp8++;
      default: n_exp16++;
    endcase
  endtask

  // Reference product built from the native multiply on sign-extended operands.
  function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic sm);
    longint mask, sa, sb, p;
    mask = (longint'(1) << w) - 1;
    sa = longint'(a) & mask;
    sb = longint'(b) & mask;
    if (sm && sa[w-1]) sa = sa - (longint'(1) << w);
    if (sm && sb[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return 64'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Run one operation with a one-cycle start pulse.
  // The operands are scrambled while the block is busy.
  // The task checks latency, busy length, result, and that done is a single pulse.
  task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic sm,
                       input logic [63:0] exp, input string tag);
    int lat;
    int busy_cnt;
    logic got;
    lat = 0;
    busy_cnt = 0;
    got = 1'b0;
    @(negedge clk);
    op_a = a; op_b = b; op_sm = sm;
    set_start(w, 1'b1);
    @(posedge clk);
    #1;
    set_start(w, 1'b0);
    if (get_busy(w)) busy_cnt++;
    op_a = ~a; op_b = b ^ 32'h5A5A_A5A5; op_sm = ~sm;
    for (int i = 0; i < w + 8 && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (get_done(w)) got = 1'b1;
      else if (get_busy(w)) busy_cnt++;
    end
    bump_exp(w);
    check_eq({tag, "_done_seen"}, 64'(got), 64'd1);
    check_eq({tag, "_latency"}, 64'(lat), 64'(w + 1));
    check_eq({tag, "_busy_len"}, 64'(busy_cnt), 64'(w + 1));
    check_eq({tag, "_product"}, get_prod(w), exp);
    $display("op w=%0d a=0x%0h b=0x%0h s=%0b product=0x%0h expected=0x%0h latency=%0d",
             w, a, b, sm, get_prod(w), exp, lat);
    @(posedge clk);
    #1;
    check_eq({tag, "_done_pulse"}, 64'(get_done(w)), 64'd0);
    check_eq({tag, "_held"}, get_prod(w), exp);
  endtask

  initial begin
    int t[3];
    int nd;
    int dcnt;
    int dtime;
    logic [31:0] ra, rb;
    logic        rs;

    rst_n = 1'b0;
    op_a = '0; op_b = '0; op_sm = 1'b0;
    start3 = 1'b0; start8 = 1'b0; start16 = 1'b0;
    #1;
    check_eq("rst_busy", 64'(busy8), 64'd0);
    check_eq("rst_done", 64'(done8), 64'd0);
    check_eq("rst_prod", 64'(prod8), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=3 unsigned regression
    do_op(3, 32'd7, 32'd7, 1'b0, 64'd49, "w3_7x7");
    do_op(3, 32'd7, 32'd5, 1'b0, 64'd35, "w3_7x5");
    do_op(3, 32'd4, 32'd1, 1'b0, 64'd4,  "w3_4x1");
    do_op(3, 32'd7, 32'd4, 1'b0, 64'd28, "w3_7x4");

    // WIDTH=8 unsigned extremes
    do_op(8, 32'd255, 32'd255, 1'b0, 64'd65025, "w8_255x255");
    do_op(8, 32'd0,   32'd200, 1'b0, 64'd0,     "w8_0x200");
    do_op(8, 32'd1,   32'd255, 1'b0, 64'd255,   "w8_1x255");

    // WIDTH=8 signed
    do_op(8, 32'h80, 32'h80, 1'b1, 64'h4000, "w8_m128xm128");
    do_op(8, 32'h80, 32'h7F, 1'b1, 64'hC080, "w8_m128x127");
    do_op(8, 32'hFF, 32'h05, 1'b1, 64'hFFFB, "w8_m1x5");
    do_op(8, 32'h00, 32'hF9, 1'b1, 64'h0000, "w8_0xm7");

    // start pulsed in the middle of CALC is ignored
    dcnt = 0;
    dtime = 0;
    @(negedge clk);
    op_a = 32'd3; op_b = 32'd5; op_sm = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) start8 = 1'b1;
      if (i == 4) start8 = 1'b0;
      if (done8) begin
        dcnt++;
        dtime = i;
      end
    end
    n_exp8++;
    check_eq("midcalc_done_cnt", 64'(dcnt), 64'd1);
    check_eq("midcalc_done_time", 64'(dtime), 64'd9);
    check_eq("midcalc_prod", 64'(prod8), 64'd15);
    $display("op w=8 a=0x3 b=0x5 s=0 extra-start product=0x%0h dones=%0d", prod8, dcnt);

    // start held high gives back-to-back operations every WIDTH+2 cycles
    nd = 0;
    t[0] = 0; t[1] = 0; t[2] = 0;
    @(negedge clk);
    op_a = 32'd7; op_b = 32'd7; op_sm = 1'b0; start3 = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 30 && nd < 3; i++) begin
      @(posedge clk);
      #1;
      if (done3) begin
        t[nd] = i;
        check_eq("held_prod", 64'(prod3), 64'd49);
        nd++;
        if (nd == 3) start3 = 1'b0;
      end
    end
    start3 = 1'b0;
    n_exp3 += 3;
    check_eq("held_cnt", 64'(nd), 64'd3);
    check_eq("held_first", 64'(t[0]), 64'd4);
    check_eq("held_gap1", 64'(t[1] - t[0]), 64'd5);
    check_eq("held_gap2", 64'(t[2] - t[1]), 64'd5);
    $display("op w=3 held start done at %0d %0d %0d", t[0], t[1], t[2]);
    repeat (2) @(posedge clk);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    op_a = 32'd255; op_b = 32'd255; op_sm = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 64'(busy8), 64'd0);
    check_eq("arst_done", 64'(done8), 64'd0);
    check_eq("arst_prod", 64'(prod8), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done8) dcnt++;
    end
    check_eq("arst_no_done", 64'(dcnt), 64'd0);
    $display("op w=8 a=0xff b=0xff s=0 aborted by reset");
    do_op(8, 32'd12, 32'd12, 1'b0, 64'd144, "w8_after_rst");

    // random operands against the reference model
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      do_op(8, ra, rb, rs, model(8, ra, rb, rs), "rnd8");
    end
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      do_op(16, ra, rb, rs, model(16, ra, rb, rs), "rnd16");
    end

    repeat (3) @(posedge clk);
    #1;
    check_eq("done_cnt3", 64'(n_done3), 64'(n_exp3));
    check_eq("done_cnt8", 64'(n_done8), 64'(n_exp8));
    check_eq("done_cnt16", 64'(n_done16), 64'(n_exp16));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
